// File: rtl/chip_idle_ctrl.sv
// chip_idle_ctrl: filters the chip idle flag, counts consecutive idle cycles and runs the PMU req/ack handshake.
// Latency: chip_is_idle rise to lp_req is SYNC_STAGES + idle_thresh + 2 cycles. Every output is registered.
// Backpressure: the PMU paces entry and exit through lp_ack. EXIT holds until lp_ack drops, so each new request starts with ack low.
//
// Ports:
//   clk, rstn      free-running clock and asynchronous active-low reset
//   chip_is_idle   raw idle flag from the idle detector (synchronised here)
//   idle_en        enables automatic entry. Low acts as a wake condition.
//   idle_thresh    consecutive synced idle cycles required before requesting
//   wake_req       external wake level
//   lp_ack         PMU acknowledge
//   lp_req         low-power request to the PMU
//   clk_gate_en    downstream clocks may be gated (SLEEP only)
//   idle_state     FSM state: RUN=0 COUNT=1 REQ=2 SLEEP=3 EXIT=4
//   idle_cnt       current idle counter (saturating)
//   lp_entry_cnt   saturating count of SLEEP entries
module chip_idle_ctrl #(
  parameter int IDLE_CNT_W  = 16,
  parameter int SYNC_STAGES = 2,   // must be >= 1
  parameter int ENTRY_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   chip_is_idle,
  input  logic                   idle_en,
  input  logic [IDLE_CNT_W-1:0]  idle_thresh,
  input  logic                   wake_req,
  input  logic                   lp_ack,
  output logic                   lp_req,
  output logic                   clk_gate_en,
  output logic [2:0]             idle_state,
  output logic [IDLE_CNT_W-1:0]  idle_cnt,
  output logic [ENTRY_CNT_W-1:0] lp_entry_cnt
);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_COUNT = 3'd1,
    ST_REQ   = 3'd2,
    ST_SLEEP = 3'd3,
    ST_EXIT  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [IDLE_CNT_W-1:0]  r_idle_cnt;
  logic [IDLE_CNT_W-1:0]  w_idle_cnt_nxt;
  logic [ENTRY_CNT_W-1:0] r_entry_cnt;
  logic [ENTRY_CNT_W-1:0] w_entry_cnt_nxt;
  logic                   r_lp_req;
  logic                   w_lp_req_nxt;
  logic                   r_clk_gate_en;
  logic                   w_clk_gate_en_nxt;
  logic                   w_idle_s;
  logic                   w_wake;
  logic                   w_cnt_max;
  logic                   w_entry_max;

  // Idle flag synchroniser. Reset state reads "not idle".
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= chip_is_idle;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_idle_s    = r_sync[SYNC_STAGES-1];
  assign w_wake      = !w_idle_s || wake_req || !idle_en;
  assign w_cnt_max   = &r_idle_cnt;
  assign w_entry_max = &r_entry_cnt;

  // Next state and next output values. The outputs are then registered, so they reflect
  // the state being entered on this edge.
  always_comb begin
    w_state_nxt       = r_state;
    w_idle_cnt_nxt    = r_idle_cnt;
    w_entry_cnt_nxt   = r_entry_cnt;
    w_lp_req_nxt      = 1'b0;
    w_clk_gate_en_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!w_wake) begin
          w_state_nxt    = ST_COUNT;
          w_idle_cnt_nxt = '0;
        end
      end
      ST_COUNT: begin
        if (w_wake) begin
          w_state_nxt    = ST_RUN;
          w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt == idle_thresh) begin
          w_state_nxt  = ST_REQ;
          w_lp_req_nxt = 1'b1;
        end else if (!w_cnt_max) begin
          // Saturates rather than wraps. A threshold lowered below the count is never matched.
          w_idle_cnt_nxt = r_idle_cnt + 1'b1;
        end
      end
      ST_REQ: begin
        w_lp_req_nxt = 1'b1;
        // An abort takes priority over an ack that arrives in the same cycle.
        if (w_wake) begin
          w_state_nxt  = ST_EXIT;
          w_lp_req_nxt = 1'b0;
        end else if (lp_ack) begin
          w_state_nxt       = ST_SLEEP;
          w_clk_gate_en_nxt = 1'b1;
          if (!w_entry_max) begin
            w_entry_cnt_nxt = r_entry_cnt + 1'b1;
          end
        end
      end
      ST_SLEEP: begin
        w_lp_req_nxt      = 1'b1;
        w_clk_gate_en_nxt = 1'b1;
        if (w_wake) begin
          w_state_nxt       = ST_EXIT;
          w_lp_req_nxt      = 1'b0;
          w_clk_gate_en_nxt = 1'b0;
        end
      end
      ST_EXIT: begin
        // Drain the PMU ack so the next request always starts from ack low.
        if (!lp_ack) begin
          w_state_nxt    = ST_RUN;
          w_idle_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_idle_cnt_nxt  = '0;
        w_entry_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_RUN;
      r_idle_cnt    <= '0;
      r_entry_cnt   <= '0;
      r_lp_req      <= 1'b0;
      r_clk_gate_en <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_entry_cnt   <= w_entry_cnt_nxt;
      r_lp_req      <= w_lp_req_nxt;
      r_clk_gate_en <= w_clk_gate_en_nxt;
    end
  end

  assign lp_req       = r_lp_req;
  assign clk_gate_en  = r_clk_gate_en;
  assign idle_state   = r_state;
  assign idle_cnt     = r_idle_cnt;
  assign lp_entry_cnt = r_entry_cnt;

endmodule

// File: tb/tb_chip_idle_ctrl.sv
// tb_chip_idle_ctrl: directed plus randomized stimulus for chip_idle_ctrl, checked every cycle against a behavioural model.
// Latency: the model advances once per clock edge. DUT outputs are compared 1 time unit after the edge.
// Backpressure: a simple PMU responder raises lp_ack after a random delay and drops it once lp_req falls.
module tb_chip_idle_ctrl;

  localparam int IW = 4;
  localparam int SS = 2;
  localparam int EW = 2;
  localparam int CNT_MAX = (1 << IW) - 1;
  localparam int ENT_MAX = (1 << EW) - 1;
  localparam int S_RUN = 0, S_COUNT = 1, S_REQ = 2, S_SLEEP = 3, S_EXIT = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          chip_is_idle;
  logic          idle_en;
  logic [IW-1:0] idle_thresh;
  logic          wake_req;
  logic          lp_ack;
  logic          lp_req;
  logic          clk_gate_en;
  logic [2:0]    idle_state;
  logic [IW-1:0] idle_cnt;
  logic [EW-1:0] lp_entry_cnt;

  chip_idle_ctrl #(.IDLE_CNT_W(IW), .SYNC_STAGES(SS), .ENTRY_CNT_W(EW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .chip_is_idle (chip_is_idle),
    .idle_en      (idle_en),
    .idle_thresh  (idle_thresh),
    .wake_req     (wake_req),
    .lp_ack       (lp_ack),
    .lp_req       (lp_req),
    .clk_gate_en  (clk_gate_en),
    .idle_state   (idle_state),
    .idle_cnt     (idle_cnt),
    .lp_entry_cnt (lp_entry_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  bit req_seen = 0;

  // Behavioural model: a delay queue for the synchroniser, the phase of the handshake,
  // an unbounded entry tally clipped only when compared.
  int m_st;
  int m_cnt;
  int m_entries;
  bit sq[$];

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_RUN;
    m_cnt = 0;
    m_entries = 0;
    sq.delete();
    for (int i = 0; i < SS; i++) sq.push_back(1'b0);
  endtask

  task automatic model_edge();
    bit idle_s;
    bit wake;
    idle_s = sq.pop_front();
    sq.push_back(chip_is_idle);
    wake = !idle_s || wake_req || !idle_en;
    if (m_st == S_RUN) begin
      if (!wake) begin m_st = S_COUNT; m_cnt = 0; end
    end else if (m_st == S_COUNT) begin
      if (wake) begin m_st = S_RUN; m_cnt = 0; end
      else if (m_cnt == int'(idle_thresh)) m_st = S_REQ;
      else m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else if (m_st == S_REQ) begin
      if (wake) m_st = S_EXIT;
      else if (lp_ack) begin m_st = S_SLEEP; m_entries++; end
    end else if (m_st == S_SLEEP) begin
      if (wake) m_st = S_EXIT;
    end else begin
      if (!lp_ack) begin m_st = S_RUN; m_cnt = 0; end
    end
  endtask

  // One clock: advance the model on the edge, then compare all outputs just after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (lp_req) req_seen = 1;
    chk("state",        int'(idle_state),   m_st);
    chk("lp_req",       int'(lp_req),       int'(m_st == S_REQ || m_st == S_SLEEP));
    chk("clk_gate_en",  int'(clk_gate_en),  int'(m_st == S_SLEEP));
    chk("idle_cnt",     int'(idle_cnt),     m_cnt);
    chk("lp_entry_cnt", int'(lp_entry_cnt), (m_entries > ENT_MAX) ? ENT_MAX : m_entries);
  endtask

  task automatic run_until_state(input int target, input int limit, input string tag, output int n);
    n = 0;
    while (int'(idle_state) != target && n < limit) begin
      step();
      n++;
    end
    chk(tag, int'(idle_state), target);
  endtask

  task automatic set_thresh(input int v);
    idle_en = 1'b0;
    step();
    idle_thresh = IW'(v);
    step();
    idle_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rstn = 1'b0;
    chip_is_idle = 1'b0;
    idle_en = 1'b1;
    idle_thresh = IW'(4);
    wake_req = 1'b0;
    lp_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",   int'(idle_state),   0);
    chk("rst_lp_req",  int'(lp_req),       0);
    chk("rst_cge",     int'(clk_gate_en),  0);
    chk("rst_cnt",     int'(idle_cnt),     0);
    chk("rst_entries", int'(lp_entry_cnt), 0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    step();

    // 1: threshold 4, PMU acks two cycles after the request
    chip_is_idle = 1'b1;
    n = 0;
    while (!lp_req && n < 40) begin step(); n++; end
    chk("t1_req_latency", n, SS + 4 + 2);
    step();
    step();
    chk("t1_wait_ack", int'(idle_state), S_REQ);
    lp_ack = 1'b1;
    step();
    chk("t1_cge_after_ack", int'(clk_gate_en), 1);
    chk("t1_entries", int'(lp_entry_cnt), 1);
    chip_is_idle = 1'b0;
    run_until_state(S_EXIT, 10, "t1_exit", n);
    lp_ack = 1'b0;
    run_until_state(S_RUN, 10, "t1_run", n);

    // 2: idle run shorter than the threshold never requests
    set_thresh(10);
    req_seen = 0;
    chip_is_idle = 1'b1;
    run_until_state(S_COUNT, 10, "t2_count", n);
    repeat (4) step();
    chip_is_idle = 1'b0;
    run_until_state(S_RUN, 10, "t2_back_run", n);
    chk("t2_cnt_zero", int'(idle_cnt), 0);
    chk("t2_no_req", int'(req_seen), 0);

    // 3: wake and ack in the same cycle while in REQ
    set_thresh(2);
    chip_is_idle = 1'b1;
    run_until_state(S_REQ, 20, "t3_req", n);
    wake_req = 1'b1;
    lp_ack = 1'b1;
    step();
    chk("t3_abort_exit", int'(idle_state), S_EXIT);
    chk("t3_cge_low", int'(clk_gate_en), 0);
    wake_req = 1'b0;
    step();
    chk("t3_hold_exit", int'(idle_state), S_EXIT);
    lp_ack = 1'b0;
    step();
    chk("t3_run", int'(idle_state), S_RUN);
    chk("t3_entries", int'(lp_entry_cnt), 1);

    // 4: idle drops in SLEEP, ack held high for a while in EXIT
    run_until_state(S_REQ, 20, "t4_req", n);
    lp_ack = 1'b1;
    step();
    chk("t4_sleep", int'(idle_state), S_SLEEP);
    chip_is_idle = 1'b0;
    run_until_state(S_EXIT, 10, "t4_exit", n);
    chk("t4_exit_latency", n, SS + 1);
    chk("t4_req_low", int'(lp_req), 0);
    chk("t4_cge_low", int'(clk_gate_en), 0);
    repeat (5) begin
      step();
      chk("t4_ack_hold", int'(idle_state), S_EXIT);
    end
    lp_ack = 1'b0;
    step();
    chk("t4_run", int'(idle_state), S_RUN);

    // 5: threshold 0, five sleeps, entry counter saturates
    set_thresh(0);
    for (int k = 0; k < 5; k++) begin
      chip_is_idle = 1'b1;
      run_until_state(S_COUNT, 10, "t5_count", n);
      step();
      chk("t5_req_next", int'(idle_state), S_REQ);
      lp_ack = 1'b1;
      step();
      chk("t5_sleep", int'(idle_state), S_SLEEP);
      chip_is_idle = 1'b0;
      run_until_state(S_EXIT, 10, "t5_exit", n);
      lp_ack = 1'b0;
      run_until_state(S_RUN, 10, "t5_run", n);
    end
    chk("t5_entries_sat", int'(lp_entry_cnt), ENT_MAX);

    // Idle counter saturation after the threshold is lowered below the count
    set_thresh(10);
    chip_is_idle = 1'b1;
    run_until_state(S_COUNT, 10, "sat_count", n);
    repeat (8) step();
    idle_thresh = IW'(3);
    repeat (10) step();
    chk("sat_cnt", int'(idle_cnt), CNT_MAX);
    chk("sat_state", int'(idle_state), S_COUNT);
    chip_is_idle = 1'b0;
    run_until_state(S_RUN, 10, "sat_run", n);

    // 6: asynchronous reset in SLEEP
    set_thresh(1);
    chip_is_idle = 1'b1;
    run_until_state(S_REQ, 20, "t6_req", n);
    lp_ack = 1'b1;
    step();
    chk("t6_cge_high", int'(clk_gate_en), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_req", int'(lp_req), 0);
    chk("t6_async_cge", int'(clk_gate_en), 0);
    chk("t6_async_state", int'(idle_state), 0);
    model_reset();
    lp_ack = 1'b0;
    chip_is_idle = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_held_cnt", int'(idle_cnt), 0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    chk("t6_rel_state", int'(idle_state), 0);
    chk("t6_rel_cnt", int'(idle_cnt), 0);

    // Randomized traffic with a responsive PMU
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 14) == 0) chip_is_idle = !chip_is_idle;
      wake_req = ($urandom_range(0, 39) == 0);
      if (idle_en) begin
        if ($urandom_range(0, 99) == 0) idle_en = 1'b0;
      end else begin
        idle_thresh = IW'($urandom_range(0, 6));
        if ($urandom_range(0, 3) == 0) idle_en = 1'b1;
      end
      if (lp_req && !lp_ack && $urandom_range(0, 2) == 0) lp_ack = 1'b1;
      else if (!lp_req && lp_ack && $urandom_range(0, 1) == 0) lp_ack = 1'b0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
